// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Operand width, op and state encodings, and two's-complement negate.
package muldiv_pkg;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] value);
        return ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for one shift-add multiply step or one restoring-divide step per cycle.
// acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b_reg;
    logic               div_reg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;

    always_comb begin
        addend   = b_reg & {WIDTH{acc_reg[0]}};
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Shifted-left remainder; it stays below 2*b so WIDTH+1 bits suffice.
        div_part = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, b_reg};
        acc_next = acc_reg;
        if (div_reg) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            b_reg   <= '0;
            div_reg <= 1'b0;
        end else if (load) begin
            acc_reg <= {{WIDTH{1'b0}}, a};
            b_reg   <= b;
            div_reg <= div_mode;
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide sequencer owning HI/LO: FSM, iteration count, sign fix-up,
// MTHI/MTLO writes and the pipeline stall request.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    muldiv_state_t      state_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               div_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               dbz_reg;

    logic               op_is_div;
    logic               op_is_signed;
    logic               zero_div;
    logic               accept;
    logic               sign_xor;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        op_is_div    = is_div_op(op);
        op_is_signed = is_signed_op(op);
        zero_div     = op_is_div && (op_b == '0);
        accept       = (state_reg == IDLE) && start && !zero_div;
        sign_xor     = op_is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        a_mag        = (op_is_signed && op_a[WIDTH-1]) ? negate(op_a) : op_a;
        b_mag        = (op_is_signed && op_b[WIDTH-1]) ? negate(op_b) : op_b;
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state_reg == CALC),
        .div_mode (op_is_div),
        .a        (a_mag),
        .b        (b_mag),
        .acc      (acc)
    );

    // Product negation runs across both halves: HI takes the carry out of LO.
    always_comb begin
        acc_hi = acc[2*WIDTH-1:WIDTH];
        acc_lo = acc[WIDTH-1:0];
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (div_reg) begin
            if (neg_lo_reg) res_lo = negate(acc_lo);
            if (neg_hi_reg) res_hi = negate(acc_hi);
        end else if (neg_hi_reg) begin
            res_lo = negate(acc_lo);
            res_hi = ~acc_hi + {{(WIDTH-1){1'b0}}, (acc_lo == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            div_reg    <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (zero_div) begin
                            dbz_reg <= 1'b1;
                        end else begin
                            dbz_reg    <= 1'b0;
                            state_reg  <= CALC;
                            count_reg  <= COUNT_W'(WIDTH - 1);
                            div_reg    <= op_is_div;
                            neg_lo_reg <= sign_xor;
                            neg_hi_reg <= op_is_div ? (op_is_signed && op_a[WIDTH-1]) : sign_xor;
                        end
                    end else begin
                        if (mthi) hi_reg <= wdata;
                        if (mtlo) lo_reg <= wdata;
                    end
                end
                CALC: begin
                    if (count_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                FIX: begin
                    hi_reg    <= res_hi;
                    lo_reg    <= res_lo;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign stall       = busy & (start | rd_req | mthi | mtlo);
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign rd_data     = rd_sel ? hi_reg : lo_reg;
    assign div_by_zero = dbz_reg;

endmodule
